// File: rtl/hack_pkg.sv
// Shared Hack ISA definitions: word/address widths, instruction field positions, ALU encodings.
// Also the combinational ALU used by the CPU. Pure definitions: no latency, no backpressure.
package hack_pkg;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 15;

   localparam int TYPE_BIT = 15;
   localparam int A_BIT    = 12;
   localparam int C_HI     = 11;
   localparam int C_LO     = 6;
   localparam int D_HI     = 5;
   localparam int D_LO     = 3;
   localparam int J_HI     = 2;
   localparam int J_LO     = 0;

   // zx nx zy ny f no; "A" forms become "M" forms when the a bit is set
   localparam logic [5:0] ALU_ZERO      = 6'b101010;
   localparam logic [5:0] ALU_ONE       = 6'b111111;
   localparam logic [5:0] ALU_NEG_ONE   = 6'b111010;
   localparam logic [5:0] ALU_D         = 6'b001100;
   localparam logic [5:0] ALU_A         = 6'b110000;
   localparam logic [5:0] ALU_NOT_D     = 6'b001101;
   localparam logic [5:0] ALU_NEG_A     = 6'b110011;
   localparam logic [5:0] ALU_D_PLUS_1  = 6'b011111;
   localparam logic [5:0] ALU_A_MINUS_1 = 6'b110010;
   localparam logic [5:0] ALU_D_PLUS_A  = 6'b000010;
   localparam logic [5:0] ALU_D_MINUS_A = 6'b010011;
   localparam logic [5:0] ALU_A_MINUS_D = 6'b000111;
   localparam logic [5:0] ALU_D_AND_A   = 6'b000000;
   localparam logic [5:0] ALU_D_OR_A    = 6'b010101;

   typedef struct packed {
      logic [WORD_W-1:0] out;
      logic              zr;
      logic              ng;
   } alu_res_t;

   function automatic alu_res_t alu(input logic [5:0] c,
                                    input logic [WORD_W-1:0] x_in,
                                    input logic [WORD_W-1:0] y_in);
      logic [WORD_W-1:0] x;
      logic [WORD_W-1:0] y;
      logic [WORD_W-1:0] r;
      x = c[5] ? '0 : x_in;
      if (c[4]) x = ~x;
      y = c[3] ? '0 : y_in;
      if (c[2]) y = ~y;
      r = c[1] ? x + y : x & y;
      if (c[0]) r = ~r;
      return '{out: r, zr: (r == '0), ng: r[WORD_W-1]};
   endfunction
endpackage

// File: rtl/hack_cpu.sv
// Hack CPU core: A/D/PC registers, ALU and jump decision; one instruction per clk.
// Latency: state updates on the edge that ends the instruction; no backpressure (always executes).
module hack_cpu
   import hack_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] instr,
   input  logic [WORD_W-1:0] in_m,
   output logic [WORD_W-1:0] out_m,
   output logic              write_m,
   output logic [ADDR_W-1:0] addr_m,
   output logic [ADDR_W-1:0] pc,
   output logic [WORD_W-1:0] d_reg
);
   logic [WORD_W-1:0] a_reg;
   alu_res_t          res;
   logic              is_c;
   logic              jump;
   logic [2:0]        dst;
   logic [2:0]        jmp;

   always_comb begin
      is_c = instr[TYPE_BIT];
      dst  = instr[D_HI:D_LO];
      jmp  = instr[J_HI:J_LO];
      res  = alu(instr[C_HI:C_LO], d_reg, instr[A_BIT] ? in_m : a_reg);
      jump = is_c & ((jmp[2] & res.ng) | (jmp[1] & res.zr) | (jmp[0] & ~res.zr & ~res.ng));
   end

   assign out_m   = res.out;
   assign write_m = is_c & dst[0];
   assign addr_m  = a_reg[ADDR_W-1:0];

   // Jump target and RAM address both use the pre-edge A, even when A is also a destination
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg <= '0;
         d_reg <= '0;
         pc    <= '0;
      end else begin
         if (!is_c)
            a_reg <= instr;
         else if (dst[2])
            a_reg <= res.out;
         if (is_c && dst[1])
            d_reg <= res.out;
         pc <= jump ? a_reg[ADDR_W-1:0] : pc + 1'b1;
      end
   end
endmodule

// File: rtl/hack_mem.sv
// Instruction ROM (combinational read, preloaded via array m) and data RAM (comb read, sync write).
// Latency: reads 0 cycles, writes land on the clock edge; no backpressure. Out-of-range reads give 0.
module hack_rom
   import hack_pkg::*;
#(
   parameter int DEPTH = 32768
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [WORD_W-1:0] data
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];

   logic [WORD_W-1:0] m [DEPTH];

   assign data = ({1'b0, addr} < LIMIT) ? m[addr[AW-1:0]] : '0;
endmodule

module hack_ram
   import hack_pkg::*;
#(
   parameter int DEPTH = 16384
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              we,
   output logic [WORD_W-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];

   logic [WORD_W-1:0] m [DEPTH];
   logic              in_range;

   assign in_range = ({1'b0, addr} < LIMIT);
   assign rdata    = in_range ? m[addr[AW-1:0]] : '0;

   // Contents survive reset; only a write that would land during reset is dropped
   always_ff @(posedge clk) begin
      if (we && in_range && !reset)
         m[addr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/hack_computer.sv
// Complete Hack computer: CPU fetching from ROM instance "rom", data in RAM instance "ram".
// Latency: one instruction per clk, no stalls; no backpressure. Debug ports expose PC/A/D/ALU.
module hack_computer
   import hack_pkg::*;
#(
   parameter int ROM_DEPTH = 32768,
   parameter int RAM_DEPTH = 16384
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] pc,
   output logic [WORD_W-1:0] instr,
   output logic [ADDR_W-1:0] addr_m,
   output logic [WORD_W-1:0] d_reg,
   output logic [WORD_W-1:0] out_m
);
   logic [WORD_W-1:0] in_m;
   logic              write_m;

   hack_cpu cpu (
      .clk     (clk),
      .reset   (reset),
      .instr   (instr),
      .in_m    (in_m),
      .out_m   (out_m),
      .write_m (write_m),
      .addr_m  (addr_m),
      .pc      (pc),
      .d_reg   (d_reg)
   );

   hack_rom #(.DEPTH(ROM_DEPTH)) rom (
      .addr (pc),
      .data (instr)
   );

   hack_ram #(.DEPTH(RAM_DEPTH)) ram (
      .clk   (clk),
      .reset (reset),
      .addr  (addr_m),
      .wdata (out_m),
      .we    (write_m),
      .rdata (in_m)
   );
endmodule

// File: tb/tb_hack_computer.sv
// Directed bench for hack_computer: small programs are poked into rom.m, state is sampled on negedges.
module tb_hack_computer;
   import hack_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] pc;
   logic [15:0] instr;
   logic [14:0] addr_m;
   logic [15:0] d_reg;
   logic [15:0] out_m;

   int checks = 0;
   int errors = 0;
   logic [15:0] prog [$];

   typedef struct {
      string       name;
      logic [15:0] instr;
      logic [15:0] exp;
   } alu_vec_t;
   alu_vec_t vecs [13];

   hack_computer dut (
      .clk    (clk),
      .reset  (reset),
      .pc     (pc),
      .instr  (instr),
      .addr_m (addr_m),
      .d_reg  (d_reg),
      .out_m  (out_m)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] c_op(input logic [5:0] c);
      return {3'b111, 1'b0, c, 6'b000000};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold reset for two edges while the new program is loaded, check reset state, release on a negedge
   task automatic apply_reset(input string tag, input logic [15:0] exp_out);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 64; i++) dut.rom.m[i] = 16'h0000;
      for (int i = 0; i < prog.size(); i++) dut.rom.m[i] = prog[i];
      step(2);
      check({tag, "_rst_pc"}, 16'(pc), 16'h0000);
      check({tag, "_rst_a"}, 16'(addr_m), 16'h0000);
      check({tag, "_rst_d"}, d_reg, 16'h0000);
      check({tag, "_rst_instr"}, instr, prog[0]);
      check({tag, "_rst_out"}, out_m, exp_out);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{"d_plus_a",  c_op(ALU_D_PLUS_A),  16'd10};
      vecs[1]  = '{"d_minus_a", c_op(ALU_D_MINUS_A), 16'd4};
      vecs[2]  = '{"a_minus_d", c_op(ALU_A_MINUS_D), 16'hFFFC};
      vecs[3]  = '{"d_and_a",   c_op(ALU_D_AND_A),   16'd3};
      vecs[4]  = '{"d_or_a",    c_op(ALU_D_OR_A),    16'd7};
      vecs[5]  = '{"not_d",     c_op(ALU_NOT_D),     16'hFFF8};
      vecs[6]  = '{"neg_one",   c_op(ALU_NEG_ONE),   16'hFFFF};
      vecs[7]  = '{"zero",      c_op(ALU_ZERO),      16'h0000};
      vecs[8]  = '{"one",       c_op(ALU_ONE),       16'h0001};
      vecs[9]  = '{"pass_d",    c_op(ALU_D),         16'd7};
      vecs[10] = '{"pass_a",    c_op(ALU_A),         16'd3};
      vecs[11] = '{"neg_a",     c_op(ALU_NEG_A),     16'hFFFD};
      vecs[12] = '{"d_plus_1",  c_op(ALU_D_PLUS_1),  16'd8};

      // A then C: @5, D=A, M=D
      prog = '{16'h0005, 16'hEC10, 16'hE308};
      apply_reset("ac", 16'h0000);
      step(1);
      check("ac_pc1", 16'(pc), 16'd1);
      check("ac_a", 16'(addr_m), 16'd5);
      step(1);
      check("ac_d", d_reg, 16'd5);
      step(1);
      check("ac_ram5", dut.ram.m[5], 16'd5);
      check("ac_pc3", 16'(pc), 16'd3);

      // ALU sweep with D=7, A=3: @7, D=A, @3, then comp-only instructions from address 3
      prog = '{16'h0007, 16'hEC10, 16'h0003};
      foreach (vecs[i]) prog.push_back(vecs[i].instr);
      apply_reset("alu", 16'h0000);
      step(3);
      check("alu_d", d_reg, 16'd7);
      check("alu_a", 16'(addr_m), 16'd3);
      for (int i = 0; i < 13; i++) begin
         check({"alu_pc_", vecs[i].name}, 16'(pc), 16'(3 + i));
         check({"alu_", vecs[i].name}, out_m, vecs[i].exp);
         step(1);
      end

      // Jumps: JEQ taken on zero, JGT not taken on zero, JMP, JLT taken on 0x8000
      prog = '{16'h000A, 16'hEA90, 16'hE302};
      for (int i = 3; i < 10; i++) prog.push_back(16'h0000);
      prog.push_back(16'hE301);                     // 10: D;JGT
      prog.push_back(16'h0014);                     // 11: @20
      prog.push_back(16'hEA87);                     // 12: 0;JMP
      for (int i = 13; i < 20; i++) prog.push_back(16'h0000);
      prog.push_back(16'h7FFF);                     // 20: @32767
      prog.push_back(16'hEC10);                     // 21: D=A
      prog.push_back(16'hE7D0);                     // 22: D=D+1
      prog.push_back(16'h001E);                     // 23: @30
      prog.push_back(16'hE304);                     // 24: D;JLT
      apply_reset("jmp", 16'h0000);
      step(3);
      check("jeq_taken", 16'(pc), 16'd10);
      step(1);
      check("jgt_not_taken", 16'(pc), 16'd11);
      step(2);
      check("jmp_taken", 16'(pc), 16'd20);
      step(3);
      check("jmp_d_8000", d_reg, 16'h8000);
      step(2);
      check("jlt_taken", 16'(pc), 16'd30);

      // Multiply R2 = R0 * R1 with R0=3, R1=4
      prog = '{16'h0003, 16'hEC10, 16'h0000, 16'hE308, 16'h0004, 16'hEC10, 16'h0001, 16'hE308,
               16'h0002, 16'hEA88,
               16'h0001, 16'hFC10, 16'h0016, 16'hE302, 16'h0000, 16'hFC10, 16'h0002, 16'hF088,
               16'h0001, 16'hFC88, 16'h000A, 16'hEA87,
               16'h0016, 16'hEA87};
      apply_reset("mul", 16'h0000);
      for (int i = 0; i < 170 && pc != 15'd22; i++) step(1);
      check("mul_end_reached", 16'(pc), 16'd22);
      check("mul_r2", dut.ram.m[2], 16'd12);
      check("mul_r0", dut.ram.m[0], 16'd3);
      check("mul_r1", dut.ram.m[1], 16'd0);
      step(2);
      check("mul_end_hold", 16'(pc), 16'd22);

      // AM=M+1 at A=20 with RAM[20]=6, then A=0;JMP uses old A=9
      prog = '{16'h0006, 16'hEC10, 16'h0014, 16'hE308, 16'hFDE8, 16'h0009, 16'hEAA7};
      apply_reset("am", 16'h0000);
      step(5);
      check("am_ram20", dut.ram.m[20], 16'd7);
      check("am_a", 16'(addr_m), 16'd7);
      check("am_d", d_reg, 16'd6);
      step(2);
      check("ajmp_old_a", 16'(pc), 16'd9);
      check("ajmp_new_a", 16'(addr_m), 16'd0);

      // ROM[0] is M=D-1: its write to RAM[0] must not happen while reset is held
      prog = '{16'hE388, 16'h0005, 16'hEC10};
      apply_reset("mid", 16'hFFFF);
      check("rst_write_suppressed", dut.ram.m[0], 16'd3);
      step(3);
      check("mid_ram0", dut.ram.m[0], 16'hFFFF);
      check("mid_d_before", d_reg, 16'd5);
      #2 reset = 1'b1;
      #1;
      check("mid_async_pc", 16'(pc), 16'h0000);
      check("mid_async_a", 16'(addr_m), 16'h0000);
      check("mid_async_d", d_reg, 16'h0000);
      step(2);
      check("mid_keep_ram20", dut.ram.m[20], 16'd7);
      check("mid_keep_ram2", dut.ram.m[2], 16'd12);
      reset = 1'b0;

      // Out-of-range RAM access and PC wrap
      prog = '{16'h0009, 16'hEC10, 16'h4000, 16'hE308, 16'hFC10, 16'h7FFF, 16'hEA87};
      dut.rom.m[32767] = 16'h0000;
      apply_reset("wrap", 16'h0000);
      step(5);
      check("oor_read_zero", d_reg, 16'h0000);
      check("oor_no_alias", dut.ram.m[0], 16'hFFFF);
      step(2);
      check("wrap_pc_max", 16'(pc), 16'h7FFF);
      step(1);
      check("wrap_pc_zero", 16'(pc), 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
